parser: RTL and testbench

- Upstream stage of the dictionary word finder.
- Scans the input line buffer from the current >IN offset, skips leading delimiters, and copies the next token into the TIB area as a counted string: length byte at tib, characters at tib+1 onward.
- Reports the updated >IN offset and token length, then holds done until released.
- Drives the shared byte memory through the same 8-bit bus master interface as the finder. Both are never active at once.

---
 rtl/forthsuper_pkg.sv | 40 ++++
 rtl/ibus8.sv | 13 +
 rtl/parser.sv | 159 +++++++++++++++
 tb/tb_parser.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/forthsuper_pkg.sv
// Types and helpers shared by the Forth front-end blocks: the parser that
// extracts tokens and the dictionary finder that looks them up.
package forthsuper_pkg;

  localparam logic [7:0] BL = 8'h20;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SKP  = 3'd1,
    SEV  = 3'd2,
    WR   = 3'd3,
    CRD  = 3'd4,
    CEV  = 3'd5,
    LEN  = 3'd6,
    DONE = 3'd7
  } parser_sts;

  typedef enum logic [2:0] {
    FND_IDLE = 3'd0,
    FND_LFA  = 3'd1,
    FND_LEV  = 3'd2,
    FND_CMP  = 3'd3,
    FND_CEV  = 3'd4,
    FND_NXT  = 3'd5,
    FND_HIT  = 3'd6,
    FND_MISS = 3'd7
  } finder_sts;

  // A blank delimiter stands for all control characters and space.
  function automatic logic isd(input logic [7:0] x, input logic [7:0] delim);
    logic r;
    if (delim == BL) begin
      r = (x <= BL);
    end else begin
      r = (x == delim);
    end
    return r;
  endfunction

endpackage

// File: rtl/ibus8.sv
// Byte-wide memory bus shared by the parser and the finder; the master drives
// address, write enable and write data, read data returns on a separate port.
interface iBus8 #(
  parameter int ASZ = 17,
  parameter int DSZ = 8
);
  logic [ASZ-1:0] ai;
  logic           we;
  logic [DSZ-1:0] vi;

  modport master (output ai, output we, output vi);
  modport slave  (input ai, input we, input vi);
endinterface

// File: rtl/parser.sv
// Token parser: skips delimiters from >IN, copies the next word into TIB as a
// counted string and reports its length and the new >IN offset.
module parser
  import forthsuper_pkg::*;
#(
  parameter int DSZ    = 8,
  parameter int ASZ    = 17,
  parameter int ISZ    = 8,
  parameter int MAXLEN = 31
) (
  input  logic           clk,
  input  logic           rst_n,
  iBus8.master           bus,
  input  logic           en,
  input  logic [ASZ-1:0] ibuf,
  input  logic [ISZ-1:0] in,
  input  logic [ISZ-1:0] ntib,
  input  logic [ASZ-1:0] tib,
  input  logic [DSZ-1:0] delim,
  input  logic [DSZ-1:0] v,
  output logic           bsy,
  output logic [DSZ-1:0] len,
  output logic [ISZ-1:0] in_nxt,
  output parser_sts      st
);

  localparam logic [DSZ-1:0] MAX_CNT = DSZ'(MAXLEN);

  parser_sts      st_r;
  parser_sts      nxt_s;
  logic [ASZ-1:0] src_r;
  logic [ASZ-1:0] end_r;
  logic [ASZ-1:0] tib_r;
  logic [ASZ-1:0] base_r;
  logic [DSZ-1:0] cnt_r;
  logic [DSZ-1:0] ch_r;
  logic [DSZ-1:0] len_r;
  logic [ISZ-1:0] in_nxt_r;
  logic [ASZ-1:0] ai_s;
  logic           we_s;
  logic [DSZ-1:0] vi_s;
  logic           isd_s;
  logic           at_end_s;
  logic           room_s;

  assign isd_s    = isd(8'(v), 8'(delim));
  assign at_end_s = (src_r == end_r);
  assign room_s   = (cnt_r < MAX_CNT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r <= IDLE;
    end else begin
      st_r <= nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    nxt_s = st_r;
    case (st_r)
      IDLE: if (en) nxt_s = SKP; else nxt_s = IDLE;
      SKP:  if (at_end_s) nxt_s = LEN; else nxt_s = SEV;
      SEV:  if (isd_s) nxt_s = SKP; else nxt_s = WR;
      WR:   nxt_s = CRD;
      CRD:  if (at_end_s) nxt_s = LEN; else nxt_s = CEV;
      CEV:  if (isd_s) nxt_s = LEN; else nxt_s = WR;
      LEN:  nxt_s = DONE;
      DONE: if (en) nxt_s = DONE; else nxt_s = IDLE;
      default: nxt_s = IDLE;
    endcase
  end

  // Bus drive, decoded purely from the current state so reset clears it at once.
  always_comb begin
    ai_s = '0;
    we_s = 1'b0;
    vi_s = '0;
    case (st_r)
      SKP, CRD: begin
        if (!at_end_s) begin
          ai_s = src_r;
        end else begin
          ai_s = '0;
        end
      end
      WR: begin
        if (room_s) begin
          ai_s = tib_r + ASZ'(1) + ASZ'(cnt_r);
          we_s = 1'b1;
          vi_s = ch_r;
        end else begin
          ai_s = '0;
        end
      end
      LEN: begin
        ai_s = tib_r;
        we_s = 1'b1;
        vi_s = cnt_r;
      end
      default: begin
        ai_s = '0;
      end
    endcase
  end

  assign bus.ai = ai_s;
  assign bus.we = we_s;
  assign bus.vi = vi_s;
  assign bsy    = (st_r != IDLE) && (st_r != DONE);
  assign st     = st_r;
  assign len    = len_r;
  assign in_nxt = in_nxt_r;

  // Datapath: scan pointers, count, captured character and results.
  // A start offset at or past the line end collapses the window to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_r    <= '0;
      end_r    <= '0;
      tib_r    <= '0;
      base_r   <= '0;
      cnt_r    <= '0;
      ch_r     <= '0;
      len_r    <= '0;
      in_nxt_r <= '0;
    end else begin
      case (st_r)
        IDLE: begin
          if (en) begin
            src_r  <= ibuf + ASZ'(in);
            end_r  <= (in >= ntib) ? (ibuf + ASZ'(in)) : (ibuf + ASZ'(ntib));
            tib_r  <= tib;
            base_r <= ibuf;
            cnt_r  <= '0;
          end
        end
        SEV, CEV: begin
          src_r <= src_r + ASZ'(1);
          ch_r  <= v;
        end
        WR: begin
          if (room_s) begin
            cnt_r <= cnt_r + DSZ'(1);
          end
        end
        LEN: begin
          len_r    <= cnt_r;
          in_nxt_r <= ISZ'(src_r - base_r);
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parser.sv
// Self-checking bench for the token parser: a byte memory model answers the
// bus, and a plain scan of the line predicts the counted string and >IN.
module tb_parser;
  import forthsuper_pkg::*;

  localparam int ASZ    = 17;
  localparam int DSZ    = 8;
  localparam int ISZ    = 8;
  localparam int MAXLEN = 31;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [ASZ-1:0] ibuf = '0;
  logic [ASZ-1:0] tib = '0;
  logic [ISZ-1:0] in = '0;
  logic [ISZ-1:0] ntib = '0;
  logic [DSZ-1:0] delim = 8'h20;
  logic [DSZ-1:0] v;
  logic           bsy;
  logic [DSZ-1:0] len;
  logic [ISZ-1:0] in_nxt;
  parser_sts      st;

  iBus8 #(.ASZ(ASZ), .DSZ(DSZ)) bus_if ();

  parser #(.DSZ(DSZ), .ASZ(ASZ), .ISZ(ISZ), .MAXLEN(MAXLEN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if), .en(en), .ibuf(ibuf), .in(in),
    .ntib(ntib), .tib(tib), .delim(delim), .v(v), .bsy(bsy), .len(len),
    .in_nxt(in_nxt), .st(st)
  );

  always #5 clk = ~clk;

  logic [7:0]     mem [0:(1<<ASZ)-1];
  logic           ld_we = 1'b0;
  logic [ASZ-1:0] ld_addr = '0;
  logic [7:0]     ld_data = '0;
  int             wr_cnt = 0;

  // Memory model: one-cycle read latency, DUT writes counted, bench preload port.
  always @(posedge clk) begin
    v <= mem[bus_if.ai];
    if (bus_if.we) begin
      mem[bus_if.ai] <= bus_if.vi;
      wr_cnt <= wr_cnt + 1;
    end else if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end
  end

  int             checks = 0;
  int             failures = 0;
  logic [7:0]     line [0:255];
  logic [ASZ-1:0] cur_ibuf = 17'h00100;
  logic [ASZ-1:0] cur_tib = 17'h00400;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit tb_isd(input logic [7:0] x, input logic [7:0] d);
    if (d == 8'h20) return x <= 8'h20;
    return x == d;
  endfunction

  task automatic load(input logic [ASZ-1:0] a, input logic [7:0] d);
    ld_addr = a;
    ld_data = d;
    ld_we   = 1'b1;
    @(posedge clk); #1;
    ld_we   = 1'b0;
  endtask

  // Copy line[0..n-1] into memory, follow it with non-delimiter junk and mark TIB.
  task automatic setup(input int n);
    for (int i = 0; i < n + 3; i++)
      load(cur_ibuf + ASZ'(i), (i < n) ? line[i] : 8'h5A);
    for (int i = 0; i < 41; i++)
      load(cur_tib + ASZ'(i), 8'hEE);
  endtask

  task automatic set_str(input string s);
    for (int i = 0; i < s.len(); i++) line[i] = s[i];
  endtask

  task automatic run_parse(input int i_in, input int i_ntib, input logic [7:0] d,
                           input string tag, input int hold);
    int p, s, k, cyc, w0, exp_len, exp_in;
    bit term;
    logic [7:0] tok [0:MAXLEN-1];
    logic [ASZ-1:0] a;
    logic [7:0] len_hold, in_hold;
    p = i_in; s = 0; k = 0; term = 1'b0;
    if (p < i_ntib) begin
      while (p < i_ntib && tb_isd(line[p], d)) begin p++; s++; end
      while (p < i_ntib && !tb_isd(line[p], d)) begin
        if (k < MAXLEN) tok[k] = line[p];
        k++; p++;
      end
      if (p < i_ntib) begin p++; term = 1'b1; end
    end
    exp_len = (k > MAXLEN) ? MAXLEN : k;
    exp_in  = (i_in >= i_ntib) ? i_in : p;

    ibuf = cur_ibuf; tib = cur_tib; in = ISZ'(i_in); ntib = ISZ'(i_ntib); delim = d;
    w0 = wr_cnt; cyc = 0; en = 1'b1;
    for (int c = 0; c < 3000 && st != DONE; c++) begin
      @(posedge clk); #1;
      if (bsy) cyc++;
    end
    chk({tag, " reach_done"}, 32'(st), 32'(DONE));
    chk({tag, " bsy_low"}, 32'(bsy), 32'd0);
    chk({tag, " len"}, 32'(len), 32'(exp_len));
    chk({tag, " in_nxt"}, 32'(in_nxt), 32'(exp_in));
    if (!term) chk({tag, " bsy_cycles"}, 32'(cyc), 32'(1 + 2 * s + 3 * k + 1));
    chk({tag, " writes"}, 32'(wr_cnt - w0), 32'(exp_len + 1));
    chk({tag, " tib0"}, 32'(mem[cur_tib]), 32'(exp_len));
    for (int j = 0; j < exp_len; j++) begin
      a = cur_tib + ASZ'(1 + j);
      chk({tag, " tib_char"}, 32'(mem[a]), 32'(tok[j]));
    end
    a = cur_tib + ASZ'(exp_len + 1);
    chk({tag, " tib_untouched"}, 32'(mem[a]), 32'h000000EE);

    len_hold = len; in_hold = in_nxt;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, " hold_st"}, 32'(st), 32'(DONE));
      chk({tag, " hold_len"}, 32'(len), 32'(len_hold));
      chk({tag, " hold_in"}, 32'(in_nxt), 32'(in_hold));
      chk({tag, " hold_we"}, 32'(bus_if.we), 32'd0);
    end
    en = 1'b0;
    @(posedge clk); #1;
    chk({tag, " idle"}, 32'(st), 32'(IDLE));
    chk({tag, " idle_bus"}, {31'd0, bus_if.we} | 32'(bus_if.ai), 32'd0);
  endtask

  initial begin
    int n, r, st_in;
    logic [7:0] d;
    #1;
    chk("rst st", 32'(st), 32'(IDLE));
    chk("rst bsy", 32'(bsy), 32'd0);
    chk("rst len", 32'(len), 32'd0);
    chk("rst in_nxt", 32'(in_nxt), 32'd0);
    chk("rst bus", {31'd0, bus_if.we} | 32'(bus_if.ai) | 32'(bus_if.vi), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_str("DUP"); setup(3);
    run_parse(0, 3, 8'h20, "dup", 4);

    set_str("  ab cd"); setup(7);
    run_parse(0, 7, 8'h20, "ab", 0);
    setup(7);
    run_parse(5, 7, 8'h20, "cd", 0);

    line[0] = 8'h09; line[1] = 8'h0D; line[2] = "x"; line[3] = " "; line[4] = "y";
    setup(5);
    run_parse(0, 5, 8'h20, "tabcr_bl", 0);
    setup(5);
    run_parse(0, 5, 8'h2C, "tabcr_comma", 0);

    for (int i = 0; i < 40; i++) line[i] = 8'h41 + 8'(i % 26);
    line[40] = " ";
    for (int i = 41; i < 45; i++) line[i] = "q";
    setup(45);
    run_parse(0, 45, 8'h20, "long", 0);

    for (int i = 0; i < 10; i++) line[i] = "w";
    setup(10);
    run_parse(10, 10, 8'h20, "at_end", 0);

    for (int i = 0; i < 8; i++) line[i] = " ";
    setup(8);
    run_parse(0, 8, 8'h20, "all_blank", 0);

    cur_ibuf = 17'h1FFFC; cur_tib = 17'h0FFFE;
    set_str("hello world"); setup(11);
    run_parse(0, 11, 8'h20, "wrap", 0);
    cur_ibuf = 17'h00100; cur_tib = 17'h00400;

    set_str("abc def"); setup(7);
    ibuf = cur_ibuf; tib = cur_tib; in = 8'd0; ntib = 8'd7; delim = 8'h20; en = 1'b1;
    for (int c = 0; c < 100 && st != CEV; c++) begin @(posedge clk); #1; end
    chk("abort reach_cev", 32'(st), 32'(CEV));
    rst_n = 1'b0; #1;
    chk("abort bsy", 32'(bsy), 32'd0);
    chk("abort st", 32'(st), 32'(IDLE));
    chk("abort we", 32'(bus_if.we), 32'd0);
    en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    setup(7);
    run_parse(0, 7, 8'h20, "after_rst", 0);
    setup(7);
    run_parse(4, 7, 8'h20, "after_rst2", 0);

    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(0, 70);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 11);
        if (t % 4 == 3 && r < 10) line[i] = 8'h61 + 8'($urandom_range(0, 25));
        else if (r < 3) line[i] = " ";
        else if (r == 3) line[i] = 8'h09;
        else if (r == 4) line[i] = ",";
        else line[i] = 8'h61 + 8'($urandom_range(0, 25));
      end
      st_in = $urandom_range(0, n + 2);
      d = ($urandom_range(0, 2) == 0) ? 8'h2C : 8'h20;
      setup(n);
      run_parse(st_in, n, d, "rand", 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
